// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-wide big-endian data memory
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Upper bound of the last byte of the addressed word, widened so addr+3 cannot wrap.
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      state;
    state_t      state_next;

    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        bad_req;
    logic [32:0] last_byte;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [15:0] lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = req_valid && (state == IDLE);

    // Reject misaligned, illegal-size and out-of-range requests at accept time.
    always_comb begin
        last_byte = {1'b0, req_addr & ~32'd3} + 33'd3;
        bad_req   = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                 || (last_byte >= MEM_LIMIT);
    end

    // Big-endian lane selection: offset 0 lives in bits 31:24, so the shift shrinks as offset grows.
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = 32'hFFFF_FFFF;
        case (size_q)
            2'b00: begin
                lane_shift = {~off_q, 3'b000};
                lane_mask  = 32'h0000_00FF << lane_shift;
            end
            2'b01: begin
                lane_shift = off_q[1] ? 5'd0 : 5'd16;
                lane_mask  = 32'h0000_FFFF << lane_shift;
            end
            default: ;
        endcase
        lane   = 16'(mem_rdata >> lane_shift);
        merged = (mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
        case (size_q)
            2'b00:   load_ext = {{24{~unsigned_q & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{~unsigned_q & lane[15]}}, lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state decode and Moore strobes.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad_req)                  state_next = ERR;
                    else if (!req_write)          state_next = RD;
                    else if (req_size == 2'b10)   state_next = WR;
                    else                          state_next = RMW_RD;
                end
            end
            RD: begin
                mem_read   = 1'b1;
                state_next = RESP;
            end
            RMW_RD: begin
                mem_read   = 1'b1;
                state_next = WR;
            end
            WR: begin
                mem_write  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, request latches, memory address/data and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                off_q      <= req_addr[1:0];
                wdata_q    <= req_wdata;
                mem_addr   <= req_addr & ~32'd3;
                mem_wdata  <= req_wdata;
                resp_rdata <= 32'd0;
            end
            if (state == RD && !write_q) begin
                resp_rdata <= load_ext;
            end
            if (state == RMW_RD) begin
                mem_wdata <= merged;
            end
        end
    end

endmodule
